// File: rtl/hh_mm_time_setter_if.sv
// Button, running-time and preset/load bundle between the time setter and the
// clock counters. The setter sits on the slave side; the surrounding logic
// (buttons, counters, display) sits on the master side.
interface hh_mm_time_setter_if;
    logic       mode_btn;
    logic       inc_btn;
    logic [3:0] cur_min_units;
    logic [2:0] cur_min_tens;
    logic [4:0] cur_hour;
    logic [3:0] set_min_units;
    logic [2:0] set_min_tens;
    logic [4:0] set_hour;
    logic       load;
    logic       editing;
    logic       blank_hour;
    logic       blank_min;

    modport master (
        output mode_btn, inc_btn, cur_min_units, cur_min_tens, cur_hour,
        input  set_min_units, set_min_tens, set_hour, load, editing,
               blank_hour, blank_min
    );

    modport slave (
        input  mode_btn, inc_btn, cur_min_units, cur_min_tens, cur_hour,
        output set_min_units, set_min_tens, set_hour, load, editing,
               blank_hour, blank_min
    );
endinterface

// File: rtl/hh_mm_time_setter.sv
// hh_mm_time_setter: turns raw mode/inc push-buttons into a debounced edit
// sequence (capture, edit hour, edit minutes, commit) that presets the hh:mm
// counters with a one-cycle load strobe, and flags which field should blink.
module hh_mm_time_setter #(
    parameter int DEBOUNCE    = 4,
    parameter int BLINK_HALF  = 8,
    parameter int REPEAT_DLY  = 16,
    parameter int REPEAT_RATE = 4,
    parameter int TIMEOUT     = 256
) (
    input  logic               clk,
    input  logic               rst,
    hh_mm_time_setter_if.slave bus
);
    localparam int DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);
    localparam int BLINK_W = (BLINK_HALF > 0) ? $clog2(2 * BLINK_HALF) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    // Hour step: 23 and anything captured out of range both roll to 0.
    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    // Minute step on the BCD-ish pair {tens, units}; 59 rolls to 00.
    function automatic logic [6:0] next_min(input logic [2:0] tens, input logic [3:0] units);
        logic [2:0] t;
        logic [3:0] u;
        if (units >= 4'd9) begin
            u = 4'd0;
            t = (tens >= 3'd5) ? 3'd0 : tens + 3'd1;
        end else begin
            u = units + 4'd1;
            t = tens;
        end
        return {t, u};
    endfunction

    // Index 0 is the mode button, index 1 the inc button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      clean;
    logic [1:0]      clean_q;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;

    logic [RPT_W-1:0]   rpt_cnt;
    logic               rpt_fast;
    logic               rpt_evt;
    logic               mode_evt;
    logic               inc_evt;

    state_t             state;
    state_t             state_nxt;
    logic               capture;
    logic               bump_hour;
    logic               bump_min;
    logic               entering_edit;
    logic               in_edit;

    logic [IDLE_W-1:0]  idle_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blank_on;

    logic [4:0]         set_hour_q;
    logic [2:0]         set_tens_q;
    logic [3:0]         set_units_q;

    assign btn_raw = {bus.inc_btn, bus.mode_btn};

    // Two-flop synchronizer, then accept a new level only after it has differed
    // from the clean level for DEBOUNCE consecutive cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            clean   <= '0;
            clean_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            clean_q <= clean;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == clean[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                    clean[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press    = clean & ~clean_q;
    assign mode_evt = press[0];
    assign rpt_evt  = clean[1] && !press[1] &&
                      (rpt_fast ? (rpt_cnt == RPT_W'(REPEAT_RATE))
                                : (rpt_cnt == RPT_W'(REPEAT_DLY)));
    assign inc_evt  = press[1] | rpt_evt;

    // Auto-repeat timer: counts cycles since the last inc event while inc is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt  <= '0;
            rpt_fast <= 1'b0;
        end else if (!clean[1]) begin
            rpt_cnt  <= '0;
            rpt_fast <= 1'b0;
        end else if (press[1]) begin
            rpt_cnt  <= RPT_W'(1);
            rpt_fast <= 1'b0;
        end else if (rpt_evt) begin
            rpt_cnt  <= RPT_W'(1);
            rpt_fast <= 1'b1;
        end else begin
            rpt_cnt  <= rpt_cnt + RPT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    // Next state and edit actions; mode wins over a same-cycle inc, and any
    // event wins over the idle timeout.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        bump_hour = 1'b0;
        bump_min  = 1'b0;
        case (state)
            RUN: begin
                if (mode_evt) begin
                    state_nxt = SET_HOUR;
                    capture   = 1'b1;
                end
            end
            SET_HOUR: begin
                if (mode_evt)                          state_nxt = SET_MIN;
                else if (inc_evt)                      bump_hour = 1'b1;
                else if (idle_cnt == IDLE_W'(TIMEOUT)) state_nxt = RUN;
            end
            SET_MIN: begin
                if (mode_evt)                          state_nxt = COMMIT;
                else if (inc_evt)                      bump_min  = 1'b1;
                else if (idle_cnt == IDLE_W'(TIMEOUT)) state_nxt = RUN;
            end
            COMMIT:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign in_edit       = (state == SET_HOUR) || (state == SET_MIN);
    assign entering_edit = ((state_nxt == SET_HOUR) || (state_nxt == SET_MIN)) &&
                           (state_nxt != state);

    // Idle timer: counts quiet cycles in an edit state and saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (entering_edit || mode_evt || inc_evt || !in_edit) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Blink phase: visible half first, restarted whenever the field is entered
    // or bumped so a just-changed digit is always shown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
        end else if (entering_edit || inc_evt) begin
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_W'(2 * BLINK_HALF - 1)) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Preset registers: loaded from the running time on capture, stepped on inc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_hour_q  <= '0;
            set_tens_q  <= '0;
            set_units_q <= '0;
        end else if (capture) begin
            set_hour_q  <= bus.cur_hour;
            set_tens_q  <= bus.cur_min_tens;
            set_units_q <= bus.cur_min_units;
        end else if (bump_hour) begin
            set_hour_q  <= next_hour(set_hour_q);
        end else if (bump_min) begin
            {set_tens_q, set_units_q} <= next_min(set_tens_q, set_units_q);
        end
    end

    assign blank_on          = (blink_cnt >= BLINK_W'(BLINK_HALF));
    assign bus.set_hour      = set_hour_q;
    assign bus.set_min_tens  = set_tens_q;
    assign bus.set_min_units = set_units_q;
    assign bus.load          = (state == COMMIT);
    assign bus.editing       = in_edit;
    assign bus.blank_hour    = (state == SET_HOUR) && blank_on;
    assign bus.blank_min     = (state == SET_MIN) && blank_on;
endmodule

// File: tb/tb_hh_mm_time_setter.sv
// Bench for hh_mm_time_setter: directed test-plan steps followed by random edit
// sessions, all checked against a press-level model of the edit sequence.
module tb_hh_mm_time_setter;
    localparam int DEBOUNCE    = 4;
    localparam int BLINK_HALF  = 8;
    localparam int REPEAT_DLY  = 16;
    localparam int REPEAT_RATE = 4;
    localparam int TIMEOUT     = 256;
    localparam int GAP         = 12;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hh_mm_time_setter_if bus ();

    hh_mm_time_setter #(
        .DEBOUNCE    (DEBOUNCE),
        .BLINK_HALF  (BLINK_HALF),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 = running, 1 = editing hour, 2 = editing minutes.
    int m_state = 0;
    int m_h     = 0;
    int m_min   = 0;
    int exp_loads = 0;
    int exp_ld_h  = 0;
    int exp_ld_min = 0;
    int c_h   = 0;
    int c_min = 0;

    // Observations gathered every cycle.
    int          load_cnt = 0;
    int          ld_h     = 0;
    int          ld_min   = 0;
    int          min_chg  = 0;
    int          vis_left = 0;
    logic [11:0] prev_set = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [11:0] cur_set;
        @(posedge clk);
        #1;
        if (bus.load === 1'b1) begin
            load_cnt++;
            ld_h   = int'(bus.set_hour);
            ld_min = int'(bus.set_min_tens) * 10 + int'(bus.set_min_units);
            check("load_vs_editing", bus.editing, 0);
        end
        cur_set = {bus.set_hour, bus.set_min_tens, bus.set_min_units};
        if (cur_set !== prev_set) begin
            if (cur_set[6:0] !== prev_set[6:0]) min_chg++;
            prev_set = cur_set;
            vis_left = BLINK_HALF;
        end
        if (vis_left > 0) begin
            check("visible_after_change", bus.blank_hour | bus.blank_min, 0);
            vis_left--;
        end
    endtask

    task automatic set_cur(input int h, input int mins);
        c_h   = h;
        c_min = mins;
        bus.cur_hour      = 5'(h);
        bus.cur_min_tens  = 3'(mins / 10);
        bus.cur_min_units = 4'(mins % 10);
    endtask

    function automatic int n_incs(input int hold);
        if (hold > REPEAT_DLY) return 2 + (hold - 1 - REPEAT_DLY) / REPEAT_RATE;
        return 1;
    endfunction

    task automatic model_mode();
        case (m_state)
            0: begin m_h = c_h; m_min = c_min; m_state = 1; end
            1: m_state = 2;
            default: begin
                exp_loads++;
                exp_ld_h   = m_h;
                exp_ld_min = m_min;
                m_state    = 0;
            end
        endcase
    endtask

    task automatic model_inc(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_state == 1)      m_h   = (m_h >= 23) ? 0 : m_h + 1;
            else if (m_state == 2) m_min = (m_min + 1) % 60;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_hour"},    bus.set_hour,      m_h);
        check({tag, "_tens"},    bus.set_min_tens,  m_min / 10);
        check({tag, "_units"},   bus.set_min_units, m_min % 10);
        check({tag, "_editing"}, bus.editing,       (m_state != 0) ? 1 : 0);
        check({tag, "_loads"},   load_cnt,          exp_loads);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {bus.set_hour, bus.set_min_tens, bus.set_min_units, bus.load,
                    bus.editing, bus.blank_hour, bus.blank_min}, 0);
    endtask

    task automatic press(input bit is_inc, input int hold, input string tag);
        if (is_inc) bus.inc_btn = 1'b1;
        else        bus.mode_btn = 1'b1;
        repeat (hold) tick();
        bus.inc_btn  = 1'b0;
        bus.mode_btn = 1'b0;
        repeat (GAP) tick();
        if (is_inc) model_inc(n_incs(hold));
        else        model_mode();
        check_model(tag);
    endtask

    task automatic check_commit(input string tag);
        check({tag, "_ld_hour"}, ld_h,   exp_ld_h);
        check({tag, "_ld_min"},  ld_min, exp_ld_min);
    endtask

    initial begin
        rst          = 1'b0;
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        set_cur(0, 0);

        // Reset state.
        repeat (3) tick();
        check_zero("reset_initial");
        rst = 1'b1;
        repeat (2) tick();
        check_zero("after_release");

        // Enter an edit, then reset in the middle of it with inc held.
        set_cur(9, 30);
        press(1'b0, 6, "enter_pre_reset");
        rst = 1'b0;
        #1;
        m_state = 0; m_h = 0; m_min = 0;
        check_zero("reset_mid_edit");
        bus.inc_btn = 1'b1;
        repeat (3) tick();
        check_zero("reset_hold");
        bus.inc_btn = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        check_zero("post_reset");
        check_model("post_reset");

        // Capture 13:47.
        set_cur(13, 47);
        press(1'b0, 6, "capture");
        check("capture_hour_13", bus.set_hour, 13);
        check("capture_tens_4", bus.set_min_tens, 4);
        check("capture_units_7", bus.set_min_units, 7);
        check("capture_editing", bus.editing, 1);

        // Hour wrap 22 -> 23 -> 0, then commit 00:47.
        for (int i = 0; i < 9; i++) press(1'b1, 5, "hour_step");
        check("hour_at_22", bus.set_hour, 22);
        press(1'b1, 5, "hour_23");
        check("hour_is_23", bus.set_hour, 23);
        press(1'b1, 5, "hour_0");
        check("hour_wraps_0", bus.set_hour, 0);
        press(1'b0, 6, "to_min");
        press(1'b0, 6, "commit1");
        check("commit1_count", load_cnt, 1);
        check("commit1_hour", ld_h, 0);
        check("commit1_min", ld_min, 47);
        check("commit1_editing", bus.editing, 0);
        check_commit("commit1");

        // Minute wrap 59 -> 00 with hour 23 untouched.
        set_cur(23, 59);
        press(1'b0, 6, "mw_capture");
        press(1'b0, 6, "mw_to_min");
        press(1'b1, 5, "mw_inc");
        check("mw_tens_0", bus.set_min_tens, 0);
        check("mw_units_0", bus.set_min_units, 0);
        check("mw_hour_23", bus.set_hour, 23);
        press(1'b0, 6, "mw_commit");
        check_commit("mw_commit");

        // Bounce rejection and press latency.
        set_cur(5, 10);
        press(1'b0, 6, "bn_capture");
        bus.inc_btn = 1'b1;
        repeat (DEBOUNCE - 1) tick();
        bus.inc_btn = 1'b0;
        repeat (GAP) tick();
        check("glitch_ignored", bus.set_hour, 5);
        bus.inc_btn = 1'b1;
        repeat (2 + DEBOUNCE) tick();
        check("before_press_edge", bus.set_hour, 5);
        tick();
        check("at_press_edge", bus.set_hour, 6);
        repeat (3) tick();
        bus.inc_btn = 1'b0;
        repeat (GAP) tick();
        model_inc(n_incs(2 + DEBOUNCE + 1 + 3));
        check_model("bounce");

        // Auto-repeat in SET_MIN: five increments from 10 to 15.
        press(1'b0, 6, "rp_to_min");
        min_chg = 0;
        press(1'b1, REPEAT_DLY + 3 * REPEAT_RATE + 1, "repeat");
        check("repeat_count", min_chg, 5);
        check("repeat_units", bus.set_min_units, 5);
        press(1'b0, 6, "rp_commit");
        check_commit("rp_commit");

        // Simultaneous mode+inc from SET_HOUR, then idle into the timeout.
        set_cur(8, 20);
        press(1'b0, 6, "to_capture");
        bus.mode_btn = 1'b1;
        bus.inc_btn  = 1'b1;
        repeat (2 + DEBOUNCE + 1) tick();
        model_mode();
        check_model("simultaneous");
        check("sim_hour_kept", bus.set_hour, 8);
        for (int j = 1; j <= TIMEOUT; j++) begin
            if (j == 3) begin
                bus.mode_btn = 1'b0;
                bus.inc_btn  = 1'b0;
            end
            tick();
            if (j == BLINK_HALF - 1) check("blink_visible", bus.blank_min, 0);
            if (j == BLINK_HALF)     check("blink_blank_min", bus.blank_min, 1);
            if (j == BLINK_HALF)     check("blink_hour_quiet", bus.blank_hour, 0);
        end
        check("pre_timeout_editing", bus.editing, 1);
        tick();
        check("timeout_editing", bus.editing, 0);
        m_state = 0;
        check_model("timeout");
        repeat (4) tick();
        check("timeout_no_load", load_cnt, exp_loads);

        // Random edit sessions.
        for (int s = 0; s < 6; s++) begin
            set_cur(int'($urandom_range(31, 0)), int'($urandom_range(59, 0)));
            if ($urandom_range(1, 0) == 1) press(1'b1, int'($urandom_range(40, 4)), "rnd_run_inc");
            press(1'b0, int'($urandom_range(10, 4)), "rnd_capture");
            repeat ($urandom_range(2, 0)) press(1'b1, int'($urandom_range(40, 4)), "rnd_hour");
            press(1'b0, int'($urandom_range(10, 4)), "rnd_to_min");
            repeat ($urandom_range(2, 0)) press(1'b1, int'($urandom_range(40, 4)), "rnd_min");
            press(1'b0, int'($urandom_range(10, 4)), "rnd_commit");
            check_commit("rnd_commit");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
